// File: rtl/fpmul_pkg.sv
// Shared types and constants for the binary32 multiplier normalize/round stage.
package fpmul_pkg;

  localparam int          BIAS    = 127;
  localparam int          EXP_W   = 10;
  localparam int          EXP_MAX = 255;
  localparam logic [31:0] QNAN    = 32'h7FC00000;

  typedef enum logic [1:0] {
    FP_NORMAL = 2'b00,
    FP_ZERO   = 2'b01,
    FP_INF    = 2'b10,
    FP_NAN    = 2'b11
  } fp_special_e;

  // Stage 1 register: normalized fields waiting for rounding.
  typedef struct packed {
    logic                sign;
    logic [EXP_W:0]      exp;
    logic [22:0]         mant;
    logic                guard;
    logic                sticky;
    fp_special_e         special;
  } s1_reg_t;

endpackage

// File: rtl/fpmul_round_rne.sv
// Round-to-nearest-even on a normalized 23-bit fraction, with exponent bump on carry.
module fpmul_round_rne
  import fpmul_pkg::*;
(
  input  logic [22:0]    i_mant,
  input  logic           i_guard,
  input  logic           i_sticky,
  input  logic [EXP_W:0] i_exp,
  output logic [22:0]    o_mant,
  output logic [EXP_W:0] o_exp,
  output logic           o_inexact
);

  logic        w_round_up;
  logic [23:0] w_sum;

  assign w_round_up = i_guard & (i_sticky | i_mant[0]);
  assign w_sum      = {1'b0, i_mant} + {23'b0, w_round_up};
  assign o_inexact  = i_guard | i_sticky;

  // A carry out means 1.11..1 rounded up to 10.00..0: renormalize by bumping the exponent.
  always_comb begin
    o_mant = w_sum[22:0];
    o_exp  = i_exp;
    if (w_sum[23]) begin
      o_mant = '0;
      o_exp  = i_exp + (EXP_W+1)'(1);
    end
  end

endmodule

// File: rtl/fpmul_norm_round.sv
// Two-stage valid/ready normalize + RNE round/pack stage of the binary32 multiplier.
// Optional feature macro: FPMUL_FLAGS_EN builds the {overflow, underflow, inexact} flags;
// without it out_flags is tied to zero and results are unchanged.
module fpmul_norm_round
  import fpmul_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [47:0]      in_prod,
  input  logic             in_sign,
  input  logic [EXP_W-1:0] in_exp,
  input  logic [1:0]       in_special,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_result,
  output logic [2:0]       out_flags
);

  localparam logic signed [EXP_W:0] EXP_MAX_S = (EXP_W+1)'(EXP_MAX);

  logic           r_s1_valid;
  s1_reg_t        r_s1;
  logic           r_s2_valid;
  logic [31:0]    r_result;

  s1_reg_t        w_s1_next;
  logic           w_s1_load;
  logic           w_s2_load;
  logic [22:0]    w_rnd_mant;
  logic [EXP_W:0] w_rnd_exp;
  logic           w_inexact;
  logic           w_ovf;
  logic           w_unf;
  logic [31:0]    w_result;

  assign w_s2_load = !r_s2_valid | out_ready;
  assign w_s1_load = !r_s1_valid | w_s2_load;
  assign in_ready  = w_s1_load;
  assign out_valid = r_s2_valid;
  assign out_result = r_result;

  // Normalize: pick the mantissa window by the product's leading bit.
  always_comb begin
    w_s1_next         = '0;
    w_s1_next.sign    = in_sign;
    w_s1_next.special = fp_special_e'(in_special);
    if (in_prod[47]) begin
      w_s1_next.mant   = in_prod[46:24];
      w_s1_next.guard  = in_prod[23];
      w_s1_next.sticky = |in_prod[22:0];
      w_s1_next.exp    = {in_exp[EXP_W-1], in_exp} + (EXP_W+1)'(1);
    end else begin
      w_s1_next.mant   = in_prod[45:23];
      w_s1_next.guard  = in_prod[22];
      w_s1_next.sticky = |in_prod[21:0];
      w_s1_next.exp    = {in_exp[EXP_W-1], in_exp};
    end
  end

  // Stage 1 register: holds while stage 2 is stalled and full.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1       <= '0;
    end else if (w_s1_load) begin
      r_s1_valid <= in_valid;
      if (in_valid) r_s1 <= w_s1_next;
    end
  end

  fpmul_round_rne u_round (
    .i_mant    (r_s1.mant),
    .i_guard   (r_s1.guard),
    .i_sticky  (r_s1.sticky),
    .i_exp     (r_s1.exp),
    .o_mant    (w_rnd_mant),
    .o_exp     (w_rnd_exp),
    .o_inexact (w_inexact)
  );

  assign w_ovf = $signed(w_rnd_exp) >= EXP_MAX_S;
  assign w_unf = w_rnd_exp[EXP_W] | (w_rnd_exp == '0);

  // Pack: specials bypass arithmetic; out-of-range saturates to inf or flushes to zero.
  always_comb begin
    w_result = '0;
    unique case (r_s1.special)
      FP_ZERO: w_result = {r_s1.sign, 31'b0};
      FP_INF:  w_result = {r_s1.sign, 8'hFF, 23'b0};
      FP_NAN:  w_result = QNAN;
      default: begin
        if (w_ovf)      w_result = {r_s1.sign, 8'hFF, 23'b0};
        else if (w_unf) w_result = {r_s1.sign, 31'b0};
        else            w_result = {r_s1.sign, w_rnd_exp[7:0], w_rnd_mant};
      end
    endcase
  end

  // Stage 2 register: result is frozen while the output is stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s2_valid <= 1'b0;
      r_result   <= '0;
    end else if (w_s2_load) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) r_result <= w_result;
    end
  end

`ifdef FPMUL_FLAGS_EN
  logic [2:0] w_flags;
  logic [2:0] r_flags;

  // Flags follow the same priority as the result mux; specials raise nothing.
  always_comb begin
    w_flags = 3'b000;
    if (r_s1.special == FP_NORMAL) begin
      if (w_ovf)      w_flags = 3'b101;
      else if (w_unf) w_flags = 3'b011;
      else            w_flags = {2'b00, w_inexact};
    end
  end

  // Flags register alongside the result.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_flags <= '0;
    end else if (w_s2_load && r_s1_valid) begin
      r_flags <= w_flags;
    end
  end

  assign out_flags = r_flags;
`else
  logic w_unused_inexact;
  assign w_unused_inexact = w_inexact;
  assign out_flags        = 3'b000;
`endif

endmodule
